// File: rtl/btn_conditioner.sv
// btn_conditioner: conditions four raw paddle buttons into move pulses.
// Each pin is synchronised and debounced. A per-button IDLE/HELD FSM then
// produces one pulse when the button is pressed and repeat pulses while it
// is held. If a player presses both directions, both of that player's
// outputs are suppressed.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_CYCLES   = 416667,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_raw,
  output logic       ply1_up,
  output logic       ply1_down,
  output logic       ply2_up,
  output logic       ply2_down,
  output logic [3:0] btn_state
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW = $clog2(REPEAT_CYCLES);
  localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RCNT_LAST = RW'(REPEAT_CYCLES - 1);

  typedef enum logic {IDLE = 1'b0, HELD = 1'b1} rep_state_e;

  logic [3:0]    pressed_raw;
  logic [3:0]    sync1_q, sync1_d;
  logic [3:0]    sync2_q, sync2_d;
  logic [3:0]    stable_q, stable_d;
  logic [DW-1:0] dcnt_q [4];
  logic [DW-1:0] dcnt_d [4];
  rep_state_e    state_q [4];
  rep_state_e    state_d [4];
  logic [RW-1:0] rcnt_q [4];
  logic [RW-1:0] rcnt_d [4];
  logic [3:0]    pulse;
  logic [3:0]    out_q, out_d;

  // Normalise pin polarity so that 1 always means pressed
  always_comb begin
    pressed_raw = (ACTIVE_LOW != 0) ? ~btn_raw : btn_raw;
  end

  // Two-stage synchroniser feeding the debouncer
  always_comb begin
    sync1_d = pressed_raw;
    sync2_d = sync1_q;
  end

  // Accept a new level only after it has disagreed for DEBOUNCE_CYCLES straight clocks
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 4; i++) begin
      dcnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (dcnt_q[i] == DCNT_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + DW'(1);
        end
      end
    end
  end

  // Synchroniser and debounce state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      stable_q <= '0;
      for (int i = 0; i < 4; i++) begin
        dcnt_q[i] <= '0;
      end
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      for (int i = 0; i < 4; i++) begin
        dcnt_q[i] <= dcnt_d[i];
      end
    end
  end

  // Repeat FSM state and repeat-counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= IDLE;
        rcnt_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        rcnt_q[i]  <= rcnt_d[i];
      end
    end
  end

  // Repeat FSM next state: release wins over the repeat terminal count
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      rcnt_d[i]  = rcnt_q[i];
      case (state_q[i])
        IDLE: begin
          if (stable_q[i]) begin
            state_d[i] = HELD;
            rcnt_d[i]  = '0;
          end
        end
        HELD: begin
          if (!stable_q[i]) begin
            state_d[i] = IDLE;
          end else if (rcnt_q[i] == RCNT_LAST) begin
            rcnt_d[i] = '0;
          end else begin
            rcnt_d[i] = rcnt_q[i] + RW'(1);
          end
        end
        default: begin
          state_d[i] = IDLE;
        end
      endcase
    end
  end

  // Repeat FSM output: pulse on the initial press and on every repeat terminal count
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pulse[i] = stable_q[i] && ((state_q[i] == IDLE) || (rcnt_q[i] == RCNT_LAST));
    end
  end

  // Suppress a direction while the same player's opposite button is held
  always_comb begin
    out_d[0] = pulse[0] & ~stable_q[1];
    out_d[1] = pulse[1] & ~stable_q[0];
    out_d[2] = pulse[2] & ~stable_q[3];
    out_d[3] = pulse[3] & ~stable_q[2];
  end

  // Output register, cleared at once by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign ply1_up   = out_q[0];
  assign ply1_down = out_q[1];
  assign ply2_up   = out_q[2];
  assign ply2_down = out_q[3];
  assign btn_state = stable_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Testbench for btn_conditioner: an active-high and an active-low instance
// see complementary pins and must behave identically. Expected values come
// from a sample-history reference model, hand-written expectation tables
// and directed sequences.
module tb_btn_conditioner;

  localparam int DEB = 4;
  localparam int REP = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_raw;
  logic [3:0] btn_raw_n;

  logic       hi_p1u, hi_p1d, hi_p2u, hi_p2d;
  logic [3:0] hi_state;
  logic       lo_p1u, lo_p1d, lo_p2u, lo_p2d;
  logic [3:0] lo_state;
  logic [3:0] hi_out, lo_out;

  assign btn_raw_n = ~btn_raw;
  assign hi_out = {hi_p2d, hi_p2u, hi_p1d, hi_p1u};
  assign lo_out = {lo_p2d, lo_p2u, lo_p1d, lo_p1u};

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  btn_conditioner #(.DEBOUNCE_CYCLES(DEB), .REPEAT_CYCLES(REP), .ACTIVE_LOW(0)) dut_hi (
    .clk(clk), .rst(rst), .btn_raw(btn_raw),
    .ply1_up(hi_p1u), .ply1_down(hi_p1d), .ply2_up(hi_p2u), .ply2_down(hi_p2d),
    .btn_state(hi_state)
  );

  btn_conditioner #(.DEBOUNCE_CYCLES(DEB), .REPEAT_CYCLES(REP), .ACTIVE_LOW(1)) dut_lo (
    .clk(clk), .rst(rst), .btn_raw(btn_raw_n),
    .ply1_up(lo_p1u), .ply1_down(lo_p1d), .ply2_up(lo_p2u), .ply2_down(lo_p2d),
    .btn_state(lo_state)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: histories of pressed samples and of synchronised values
  logic [3:0] phist[$];
  logic [3:0] shist[$];
  logic [3:0] m_stable;
  logic [3:0] m_prev_st;
  logic [3:0] m_out;
  int         m_edge;
  int         m_start[4];

  typedef struct {
    int         edge_no;
    logic [3:0] exp_out;
    logic [3:0] exp_state;
  } vec_t;

  vec_t press_tbl[$];

  task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    phist.delete();
    shist.delete();
    m_stable  = '0;
    m_prev_st = '0;
    m_out     = '0;
    m_edge    = 0;
    for (int i = 0; i < 4; i++) m_start[i] = 0;
  endtask

  // One rising edge of the model; pressed is the normalised pin value sampled at that edge
  task automatic modelStep(input logic [3:0] pressed);
    logic [3:0] s;
    logic [3:0] st_k;
    logic [3:0] pulse;
    logic [3:0] newst;
    logic       all_diff;
    s = (phist.size() >= 2) ? phist[phist.size() - 2] : 4'b0000;
    phist.push_back(pressed);
    if (phist.size() > 3) void'(phist.pop_front());
    st_k = m_stable;
    for (int i = 0; i < 4; i++) begin
      pulse[i] = 1'b0;
      if (st_k[i]) begin
        if (!m_prev_st[i]) begin
          pulse[i]   = 1'b1;
          m_start[i] = m_edge;
        end else if (((m_edge - m_start[i]) % REP) == 0) begin
          pulse[i] = 1'b1;
        end
      end
    end
    m_out = {pulse[3] & ~st_k[2], pulse[2] & ~st_k[3], pulse[1] & ~st_k[0], pulse[0] & ~st_k[1]};
    shist.push_back(s);
    if (shist.size() > DEB) void'(shist.pop_front());
    newst = m_stable;
    if (shist.size() == DEB) begin
      for (int i = 0; i < 4; i++) begin
        all_diff = 1'b1;
        for (int j = 0; j < DEB; j++) begin
          if (shist[j][i] == m_stable[i]) all_diff = 1'b0;
        end
        if (all_diff) newst[i] = ~m_stable[i];
      end
    end
    m_stable  = newst;
    m_prev_st = st_k;
    m_edge++;
  endtask

  task automatic checkOutput();
    cmp("model_out_hi", hi_out, m_out);
    cmp("model_state_hi", hi_state, m_stable);
    cmp("model_out_lo", lo_out, m_out);
    cmp("model_state_lo", lo_state, m_stable);
  endtask

  // Drive pins at a falling edge, advance one rising edge, check at the next falling edge
  task automatic applyStimulus(input logic [3:0] raw);
    btn_raw = raw;
    @(posedge clk);
    modelStep(raw);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic doReset();
    rst = 1'b1;
    modelReset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] any_out;
    logic [3:0] raw;
    int         len;
    int         k;

    // Expected results for bit0 held from edge 0
    press_tbl.push_back('{4,  4'b0000, 4'b0000});
    press_tbl.push_back('{5,  4'b0000, 4'b0001});
    press_tbl.push_back('{6,  4'b0001, 4'b0001});
    press_tbl.push_back('{7,  4'b0000, 4'b0001});
    press_tbl.push_back('{13, 4'b0000, 4'b0001});
    press_tbl.push_back('{14, 4'b0001, 4'b0001});
    press_tbl.push_back('{15, 4'b0000, 4'b0001});
    press_tbl.push_back('{21, 4'b0000, 4'b0001});
    press_tbl.push_back('{22, 4'b0001, 4'b0001});
    press_tbl.push_back('{23, 4'b0000, 4'b0001});

    // Reset with every button pressed clears outputs before any clock edge
    btn_raw = 4'b1111;
    rst     = 1'b0;
    modelReset();
    #2 rst = 1'b1;
    #1;
    cmp("reset_out_hi", hi_out, 4'b0000);
    cmp("reset_state_hi", hi_state, 4'b0000);
    cmp("reset_out_lo", lo_out, 4'b0000);
    cmp("reset_state_lo", lo_state, 4'b0000);
    btn_raw = 4'b0000;
    @(negedge clk);
    doReset();

    // Press and repeat from a table of per-edge expectations
    k = 0;
    for (int e = 0; e <= 23; e++) begin
      applyStimulus(4'b0001);
      if (k < press_tbl.size() && press_tbl[k].edge_no == e) begin
        cmp("press_out_hi", hi_out, press_tbl[k].exp_out);
        cmp("press_out_lo", lo_out, press_tbl[k].exp_out);
        cmp("press_state", hi_state, press_tbl[k].exp_state);
        k++;
      end
    end

    // Short glitch is rejected
    doReset();
    any_out = '0;
    for (int e = 0; e < 15; e++) begin
      applyStimulus((e < 3) ? 4'b0100 : 4'b0000);
      any_out = any_out | hi_out | hi_state;
    end
    cmp("glitch_none", any_out, 4'b0000);

    // Short burst, gap, then a burst long enough to be accepted
    doReset();
    for (int e = 0; e <= 10; e++) begin
      applyStimulus((e == 3) ? 4'b0000 : 4'b0100);
      if (e == 9) cmp("burst_e9", hi_out, 4'b0000);
      if (e == 10) cmp("burst_e10", hi_out, 4'b0100);
    end

    // Conflict: both ply1 directions held suppress ply1 until one is released
    doReset();
    any_out = '0;
    for (int e = 0; e <= 46; e++) begin
      applyStimulus((e >= 20 && e < 40) ? 4'b0011 : 4'b0001);
      if (e == 22) cmp("conf_e22", hi_out, 4'b0001);
      if (e == 25) cmp("conf_state", hi_state, 4'b0011);
      if (e >= 26 && e <= 45) any_out = any_out | hi_out;
      if (e == 46) cmp("conf_resume", hi_out, 4'b0001);
    end
    cmp("conf_quiet", any_out, 4'b0000);

    // Active-low instance: idle pins high give no state, pin3 low moves ply2 down
    doReset();
    for (int e = 0; e < 6; e++) applyStimulus(4'b0000);
    cmp("al_idle_state", lo_state, 4'b0000);
    doReset();
    for (int e = 0; e <= 6; e++) begin
      applyStimulus(4'b1000);
      if (e == 6) cmp("al_press", lo_out, 4'b1000);
    end

    // Reset while a pulse is on the output, then a fresh press after release
    doReset();
    for (int e = 0; e <= 5; e++) applyStimulus(4'b0001);
    btn_raw = 4'b0001;
    @(posedge clk);
    modelStep(4'b0001);
    #1;
    cmp("midhold_pulse", hi_out, 4'b0001);
    rst = 1'b1;
    #1;
    cmp("midhold_rst_hi", hi_out, 4'b0000);
    cmp("midhold_rst_lo", lo_out, 4'b0000);
    cmp("midhold_rst_state", hi_state, 4'b0000);
    modelReset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int e = 0; e <= 7; e++) begin
      applyStimulus(4'b0001);
      if (e == 5) cmp("midhold_e5", hi_out, 4'b0000);
      if (e == 6) cmp("midhold_e6", hi_out, 4'b0001);
    end

    // Randomised held patterns against the reference model
    doReset();
    for (int seg = 0; seg < 300; seg++) begin
      raw = 4'($urandom);
      if ($urandom_range(0, 3) == 0) raw = 4'b0000;
      len = $urandom_range(1, 14);
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 39) == 0) applyStimulus(raw ^ 4'($urandom));
        else applyStimulus(raw);
      end
      if ($urandom_range(0, 59) == 0) doReset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
